// File: rtl/coprosit_pkg.sv
// Shared types and constants for the coprosit result stage.
// Optional feature macro: COPROSIT_RESULT_BYPASS_EN (0-cycle bypass on an empty FIFO).
package coprosit_pkg;
  localparam int X_ID_WIDTH        = 4;
  localparam int RESULT_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
  } result_entry_t;

  // Memory completions carry only an ID; they never write the integer RF.
  function automatic result_entry_t mem_entry(input logic [X_ID_WIDTH-1:0] id);
    result_entry_t e;
    e      = '0;
    e.id   = id;
    return e;
  endfunction
endpackage

// File: rtl/coprosit_result_stage_if.sv
// Execution-stage, memory-completion and CV-X-IF result signals of the result stage.
interface coprosit_result_stage_if;
  import coprosit_pkg::*;

  logic                  ex_valid_i;
  logic                  ex_ready_o;
  logic [X_ID_WIDTH-1:0] ex_id_i;
  logic [31:0]           ex_data_i;
  logic [4:0]            ex_rd_i;
  logic                  ex_we_i;
  logic                  mem_valid_i;
  logic [X_ID_WIDTH-1:0] mem_id_i;
  logic                  xif_result_valid_o;
  logic                  xif_result_ready_i;
  logic [X_ID_WIDTH-1:0] xif_result_id_o;
  logic [31:0]           xif_result_data_o;
  logic [4:0]            xif_result_rd_o;
  logic                  xif_result_we_o;

  // The result stage itself.
  modport slave (
    input  ex_valid_i, ex_id_i, ex_data_i, ex_rd_i, ex_we_i,
    input  mem_valid_i, mem_id_i, xif_result_ready_i,
    output ex_ready_o, xif_result_valid_o, xif_result_id_o,
    output xif_result_data_o, xif_result_rd_o, xif_result_we_o
  );

  // The surrounding pipeline and core.
  modport master (
    output ex_valid_i, ex_id_i, ex_data_i, ex_rd_i, ex_we_i,
    output mem_valid_i, mem_id_i, xif_result_ready_i,
    input  ex_ready_o, xif_result_valid_o, xif_result_id_o,
    input  xif_result_data_o, xif_result_rd_o, xif_result_we_o
  );
endinterface

// File: rtl/coprosit_result_fifo.sv
// Generic result FIFO: storage, wrapping pointers and an occupancy counter.
// Full/empty come from the counter so pointer equality is never ambiguous.
module coprosit_result_fifo
  import coprosit_pkg::*;
#(
  parameter  int DEPTH = RESULT_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  result_entry_t wdata,
  input  logic          pop,
  output result_entry_t head,
  output logic [CW-1:0] count,
  output logic          empty
);
  result_entry_t mem_q [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rptr];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wrap_inc(wptr);
      if (do_pop)  rptr <= wrap_inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr] <= wdata;
  end
endmodule

// File: rtl/coprosit_result_stage.sv
// Result stage: merges memory completions and execution results into one
// in-order CV-X-IF result stream. One FIFO slot is held back for memory
// completions, which have no ready and must never be dropped.
// Optional feature macro: COPROSIT_RESULT_BYPASS_EN (0-cycle bypass on an empty FIFO).
module coprosit_result_stage
  import coprosit_pkg::*;
#(
  parameter  int DEPTH = RESULT_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  coprosit_result_stage_if.slave  res,
  output logic [CW-1:0]           count_o,
  output logic                    overflow_o
);
  result_entry_t in_entry, head, out_entry;
  logic [CW-1:0] count;
  logic [CW:0]   free;
  logic          empty, fifo_push, fifo_pop, ex_acc, in_valid, mem_drop;
  logic          bypass_take, out_valid, overflow_q;

  // Popping only looks at stored state, which keeps ex_ready free of any loop
  // through the bypass path (an empty FIFO has free = DEPTH anyway).
  assign fifo_pop = ~rst_i & ~empty & res.xif_result_ready_i;
  assign free     = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(fifo_pop);

  assign res.ex_ready_o = ~rst_i & ~res.mem_valid_i & (free >= (CW+1)'(2));
  assign ex_acc   = res.ex_valid_i & res.ex_ready_o;
  assign in_valid = res.mem_valid_i | ex_acc;
  assign in_entry = res.mem_valid_i ? mem_entry(res.mem_id_i)
                  : '{id: res.ex_id_i, data: res.ex_data_i, rd: res.ex_rd_i, we: res.ex_we_i};
  assign mem_drop = res.mem_valid_i & (free == '0);

`ifdef COPROSIT_RESULT_BYPASS_EN
  assign bypass_take = empty & in_valid & res.xif_result_ready_i;
  assign out_valid   = ~rst_i & (~empty | in_valid);
  assign out_entry   = rst_i ? '0 : ((empty & in_valid) ? in_entry : head);
`else
  assign bypass_take = 1'b0;
  assign out_valid   = ~rst_i & ~empty;
  assign out_entry   = rst_i ? '0 : head;
`endif

  assign fifo_push = ~rst_i & in_valid & ~mem_drop & ~bypass_take;

  coprosit_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (fifo_push),
    .wdata (in_entry),
    .pop   (fifo_pop),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  // Sticky flag for a memory completion that found no room.
  always_ff @(posedge clk_i) begin
    if (rst_i)         overflow_q <= 1'b0;
    else if (mem_drop) overflow_q <= 1'b1;
  end

  assign res.xif_result_valid_o = out_valid;
  assign res.xif_result_id_o    = out_entry.id;
  assign res.xif_result_data_o  = out_entry.data;
  assign res.xif_result_rd_o    = out_entry.rd;
  assign res.xif_result_we_o    = out_entry.we;
  assign count_o    = rst_i ? '0 : count;
  assign overflow_o = ~rst_i & overflow_q;
endmodule

// File: tb/tb_coprosit_result_stage.sv
// Bench for coprosit_result_stage: a queue-based reference model checks every
// cycle of directed and random traffic; a DEPTH=2 instance covers the
// full/pop/push boundary.
module tb_coprosit_result_stage;
  import coprosit_pkg::*;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  coprosit_result_stage_if ifc ();
  coprosit_result_stage_if ifc2 ();
  logic [2:0] cnt;
  logic       ovf;
  logic [1:0] cnt2;
  logic       ovf2;

  coprosit_result_stage #(.DEPTH(D)) u_dut (
    .clk_i(clk), .rst_i(rst), .res(ifc.slave), .count_o(cnt), .overflow_o(ovf)
  );
  coprosit_result_stage #(.DEPTH(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst2), .res(ifc2.slave), .count_o(cnt2), .overflow_o(ovf2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain queue of results in arrival order.
  result_entry_t q[$];
  bit m_ovf = 0;

  function automatic logic [63:0] pack_out();
    return 64'({ifc.xif_result_id_o, ifc.xif_result_data_o, ifc.xif_result_rd_o, ifc.xif_result_we_o});
  endfunction

  // One clock of the main DUT: drive, check against model, advance model.
  task automatic step(input bit r, input bit exv, input logic [3:0] exid, input logic [31:0] exd,
                      input logic [4:0] exrd, input bit exwe, input bit mv, input logic [3:0] mid,
                      input bit rdy);
    result_entry_t ex_e, in_e, exp_out;
    bit exp_rdy, in_v, exp_v, had, consumed;
    int free;
    rst = r;
    ifc.ex_valid_i = exv; ifc.ex_id_i = exid; ifc.ex_data_i = exd;
    ifc.ex_rd_i = exrd; ifc.ex_we_i = exwe;
    ifc.mem_valid_i = mv; ifc.mem_id_i = mid; ifc.xif_result_ready_i = rdy;
    ex_e = '{id: exid, data: exd, rd: exrd, we: exwe};
    had = (q.size() > 0);
    free = D - q.size() + ((had && rdy && !r) ? 1 : 0);
    exp_rdy = !r && !mv && free >= 2;
    in_v = !r && (mv || (exv && exp_rdy));
    in_e = mv ? '{id: mid, data: 32'h0, rd: 5'h0, we: 1'b0} : ex_e;
    exp_v = !r && had;
    exp_out = '0;
    if (exp_v) exp_out = q[0];
`ifdef COPROSIT_RESULT_BYPASS_EN
    if (!r && !had && in_v) begin exp_v = 1; exp_out = in_e; end
`endif
    @(negedge clk);
    chk("ex_ready", 64'(ifc.ex_ready_o), 64'(exp_rdy));
    chk("valid", 64'(ifc.xif_result_valid_o), 64'(exp_v));
    chk("result", pack_out(), 64'(exp_out));
    chk("count", 64'(cnt), r ? 64'd0 : 64'(q.size()));
    chk("overflow", 64'(ovf), r ? 64'd0 : 64'(m_ovf));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 0;
    end else begin
      consumed = 0;
      if (had && rdy) void'(q.pop_front());
      else if (exp_v && rdy) consumed = 1;
      if (in_v && !consumed) begin
        if (mv && free == 0) m_ovf = 1;
        else q.push_back(in_e);
      end
    end
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic ex_push(input logic [3:0] id, input bit rdy);
    step(0, 1, id, 32'h1000 + 32'(id), 5'(id + 1), 1'b1, 0, 0, rdy);
  endtask

  initial begin
    ifc2.ex_valid_i = 0; ifc2.ex_id_i = 0; ifc2.ex_data_i = 0; ifc2.ex_rd_i = 0;
    ifc2.ex_we_i = 0; ifc2.mem_valid_i = 0; ifc2.mem_id_i = 0; ifc2.xif_result_ready_i = 0;
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single ex result with the core ready.
    step(0, 1, 4'd3, 32'h4000_0000, 5'd5, 1'b1, 0, 0, 1);
    idle(1, 2);

    // Fill with ready low: ex_ready drops at free=1, mem still fits, drain in order.
    for (int i = 0; i < 3; i++) ex_push(4'(i), 0);
    ex_push(4'd9, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4'd7, 0);
    idle(1, 5);

    // ex and mem together: mem wins, ex retried next cycle.
    step(0, 1, 4'd4, 32'hdead_beef, 5'd9, 1'b1, 1, 4'd5, 0);
    step(0, 1, 4'd4, 32'hdead_beef, 5'd9, 1'b1, 0, 0, 0);
    idle(1, 3);

    // Overflow: full FIFO, ready low, extra mem completion is dropped and flag sticks.
    for (int i = 0; i < 3; i++) ex_push(4'(i + 8), 0);
    step(0, 0, 0, 0, 0, 0, 1, 4'd12, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4'd13, 0);
    idle(0, 2);
    idle(1, 5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 1);

    // Reset with 3 entries queued: nothing stale afterwards.
    for (int i = 0; i < 3; i++) ex_push(4'(i + 1), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 3);

    // Random traffic; mem only issued when the model has room for it.
    for (int n = 0; n < 400; n++) begin
      bit rdy, mv, r;
      int fr;
      rdy = ($urandom_range(0, 2) != 0);
      fr = D - q.size() + ((q.size() > 0 && rdy) ? 1 : 0);
      mv = (fr >= 1) && ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 79) == 0);
      step(r, bit'($urandom_range(0, 1)), 4'($urandom), $urandom, 5'($urandom), bit'($urandom),
           mv, 4'($urandom), rdy);
    end

    // DEPTH=2 boundary: full, pop and mem push in the same cycle.
    @(posedge clk); #1;
    rst2 = 0;
    ifc2.mem_valid_i = 1; ifc2.mem_id_i = 4'd1;
    @(posedge clk); #1;
    ifc2.mem_id_i = 4'd2;
    @(posedge clk); #1;
    ifc2.mem_id_i = 4'd3; ifc2.xif_result_ready_i = 1;
    @(negedge clk);
    chk("d2_full_count", 64'(cnt2), 64'd2);
    chk("d2_head_id", 64'(ifc2.xif_result_id_o), 64'd1);
    chk("d2_ex_ready", 64'(ifc2.ex_ready_o), 64'd0);
    @(posedge clk); #1;
    ifc2.mem_valid_i = 0; ifc2.xif_result_ready_i = 0;
    @(negedge clk);
    chk("d2_count_kept", 64'(cnt2), 64'd2);
    chk("d2_no_overflow", 64'(ovf2), 64'd0);
    chk("d2_next_id", 64'(ifc2.xif_result_id_o), 64'd2);
    @(posedge clk); #1;
    ifc2.mem_valid_i = 1; ifc2.mem_id_i = 4'd4;
    @(posedge clk); #1;
    ifc2.mem_valid_i = 0;
    @(negedge clk);
    chk("d2_overflow", 64'(ovf2), 64'd1);
    chk("d2_count_full", 64'(cnt2), 64'd2);
    @(posedge clk); #1;
    rst2 = 1;
    @(posedge clk); #1;
    rst2 = 0;
    @(negedge clk);
    chk("d2_reset_ovf", 64'(ovf2), 64'd0);
    chk("d2_reset_cnt", 64'(cnt2), 64'd0);
    chk("d2_reset_valid", 64'(ifc2.xif_result_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/coprosit_result_stage.md
# coprosit_result_stage

Result stage of the coprosit coprocessor, directly downstream of the execution stage and the XIF memory result path. It merges posit-unit results and memory (load/store) completions into one in-order stream on the CV-X-IF result interface. A small FIFO absorbs back-pressure from the core, and one slot is always held free so memory results, which cannot be stalled, are never dropped.

## Interface
- `DEPTH`, default 4: result FIFO entries; legal range 2..16.
- `coprosit_pkg::X_ID_WIDTH` (package constant): width of instruction IDs.

Clock and reset: one clock; reset is synchronous and active-high. Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `ex_valid_i` in 1: execution-stage result valid.
- `ex_ready_o` out 1: execution-stage result accepted.
- `ex_id_i` in X_ID_WIDTH: execution-stage result ID.
- `ex_data_i` in 32: execution-stage result data.
- `ex_rd_i` in 5: execution-stage destination register.
- `ex_we_i` in 1: execution-stage result is an integer-RF writeback.
- `mem_valid_i` in 1: memory completion; no ready, so it is always accepted.
- `mem_id_i` in X_ID_WIDTH: memory completion ID.
- `xif_result_valid_o` out 1: result valid towards the core.
- `xif_result_ready_i` in 1: core accepts the result.
- `xif_result_id_o` out X_ID_WIDTH: result ID.
- `xif_result_data_o` out 32: result data.
- `xif_result_rd_o` out 5: result destination register.
- `xif_result_we_o` out 1: result write enable.
- `count_o` out $clog2(DEPTH+1): current FIFO occupancy.
- `overflow_o` out 1: sticky error flag.

## Operation
- Push sources: a memory completion becomes entry {mem_id_i, 32'h0, 5'h0, we=0}. An execution-stage result becomes {ex_id_i, ex_data_i, ex_rd_i, ex_we_i}.
- Priority: memory beats execution. When `mem_valid_i`=1, `ex_ready_o`=0 in the same cycle.
- Popping: pop = `xif_result_valid_o & xif_result_ready_i`. Define free = DEPTH − count + pop.
- `ex_ready_o` = ~rst_i & ~mem_valid_i & (free ≥ 2). This holds back one slot for memory completions.
- Overflow: if a memory completion arrives with free = 0, the entry is dropped and `overflow_o` sets. It stays set until reset. This must never happen in a correct system, and the bench asserts on it.
- Ordering: strict FIFO. Output fields always come from the head entry.
- Empty FIFO: `xif_result_valid_o`=0 and all result fields are 0. Behaviour with the bypass compiled in is described under Configuration.
- Simultaneous push and pop: count is unchanged and the head advances. With DEPTH=2, full, pop and mem push together: the push succeeds and there is no overflow.
- Pointers: read and write pointers wrap modulo DEPTH. Full and empty are derived from the count, not from pointer equality.

## Timing
- Reset: while `rst_i`=1, and in the first cycle after it deasserts:
  - count = 0, pointers = 0, `overflow_o`=0;
  - `xif_result_valid_o`=0, result fields = 0;
  - `ex_ready_o`=0 during reset only.
- Reset asserted mid-operation discards all stored entries in the next cycle. No result is emitted.
- Latency without bypass: an entry pushed in cycle N is visible on the outputs in cycle N+1 if the FIFO was empty.
- Stability: `xif_result_valid_o` and all result fields stay stable until the pop handshake. The core must not see a withdrawn result.
- Combinational paths:
  - `ex_ready_o` depends on `mem_valid_i` and `xif_result_ready_i`.
  - The outputs depend only on registered state, unless the bypass is enabled.

## Configuration
- `COPROSIT_RESULT_BYPASS_EN` defined:
  - When the FIFO is empty, the incoming result (memory, or an accepted execution-stage result) drives the outputs in the same cycle.
  - If `xif_result_ready_i`=1, the result is not stored (0-cycle latency).
  - If ready=0, it is stored and presented from the FIFO in the next cycle.
- `COPROSIT_RESULT_BYPASS_EN` undefined: every result is registered first, giving a minimum latency of 1 cycle.

## Structure
- `coprosit_pkg` holds:
  - `result_entry_t`, a packed struct {id, data[31:0], rd[4:0], we};
  - `RESULT_FIFO_DEPTH`, default 4.
- Sub-module `coprosit_result_fifo` holds the generic storage, pointers, count and full/empty logic. The top level holds the source arbitration, ready/reservation logic, bypass and overflow flag.

## Test plan
- After reset, ex push {id=3, data=0x4000_0000, rd=5, we=1} with ready=1: without bypass, the result appears one cycle later; with bypass, it appears in the same cycle. count returns to 0.
- Hold `xif_result_ready_i`=0 with DEPTH=4 and push 3 execution results: `ex_ready_o` drops after the 3rd push (free=1). A mem push with id=7 is accepted and count=4. Release ready: results come out in order 0,1,2,7.
- Same cycle, ex_valid and mem_valid both 1: `ex_ready_o`=0 and the mem entry (we=0, data=0) is enqueued. The ex result is accepted the next cycle.
- DEPTH=2, full, ready=1, mem push: pop and push in the same cycle, count stays at 2, `overflow_o`=0.
- Force a mem push with count=DEPTH and ready=0: the entry is dropped and `overflow_o`=1 until `rst_i`.
- Assert `rst_i` with 3 entries queued: the next cycle has `xif_result_valid_o`=0 and count=0. No stale entry appears after release.
